// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes and Cause field layout.
package cp0_pkg;

  typedef enum logic [4:0] {
    CP0_COUNT   = 5'd9,
    CP0_COMPARE = 5'd11,
    CP0_STATUS  = 5'd12,
    CP0_CAUSE   = 5'd13,
    CP0_EPC     = 5'd14
  } cp0_reg_e;

  typedef enum logic [4:0] {
    EXC_SYSCALL = 5'd8,
    EXC_BREAK   = 5'd9,
    EXC_TEQ     = 5'd13
  } exc_code_e;

  localparam int unsigned STATUS_SHIFT   = 5;
  localparam int unsigned CAUSE_EXC_LSB  = 2;
  localparam int unsigned CAUSE_EXC_MSB  = 6;
  localparam int unsigned CAUSE_IP7      = 15;
  localparam logic [31:0] CAUSE_IP7_MASK = 32'(1) << CAUSE_IP7;

  // Replace the ExcCode field of a Cause value, leaving every other bit alone.
  function automatic logic [31:0] cause_with_exc(input logic [31:0] cause_v,
                                                 input logic [4:0]  code);
    logic [31:0] r;
    r = cause_v;
    r[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = code;
    return r;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare register and sticky match flag.
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_wr_i,
  input  logic        compare_wr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          tint_q, tint_d;
  logic          tick;
  logic          count_changed;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    tick          = (presc_q == PRESC_LAST);
    presc_d       = tick ? '0 : presc_q + PW'(1);
    count_d       = tick ? count_q + 32'd1 : count_q;
    compare_d     = compare_q;
    tint_d        = tint_q;
    count_changed = tick;

    if (count_wr_i) begin
      presc_d       = '0;
      count_d       = wdata_i;
      count_changed = 1'b1;
    end

    if (count_changed && (count_d == compare_q)) tint_d = 1'b1;

    // A Compare write acknowledges the interrupt and beats a simultaneous match.
    if (compare_wr_i) begin
      compare_d = wdata_i;
      tint_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      tint_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      tint_q    <= tint_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = tint_q;

endmodule

// File: rtl/cp0_regs.sv
// CP0 responder for the multi-cycle MIPS54 core: Status/Cause/EPC, exception entry and eret.
// Optional Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_regs
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mfc0,
  input  logic        mtc0,
  input  logic [31:0] pc,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  input  logic        exception,
  input  logic        eret,
  input  logic [4:0]  cause,
  output logic [31:0] rdata,
  output logic [31:0] status,
  output logic [31:0] exc_addr,
  output logic        timer_int
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count_v, compare_v;
  logic        timer_int_v;
  logic        wr_status, wr_cause, wr_epc;
  logic        unused_ok;

  assign wr_status = mtc0 && (rd == CP0_STATUS);
  assign wr_cause  = mtc0 && (rd == CP0_CAUSE);
  assign wr_epc    = mtc0 && (rd == CP0_EPC);

`ifdef CP0_TIMER_EN
  logic wr_count, wr_compare;

  assign wr_count   = mtc0 && (rd == CP0_COUNT);
  assign wr_compare = mtc0 && (rd == CP0_COMPARE);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .rst_n        (reset),
    .count_wr_i   (wr_count),
    .compare_wr_i (wr_compare),
    .wdata_i      (wdata),
    .count_o      (count_v),
    .compare_o    (compare_v),
    .timer_int_o  (timer_int_v)
  );

  assign unused_ok = mfc0;
`else
  assign count_v     = '0;
  assign compare_v   = '0;
  assign timer_int_v = 1'b0;
  assign unused_ok   = mfc0 ^ (COUNT_DIV == 0);
`endif

  // Exception outranks eret and any mtc0 to Status/Cause/EPC; eret outranks mtc0 to Status.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (exception) begin
      status_d = status_q << STATUS_SHIFT;
      cause_d  = cause_with_exc(cause_q, cause);
      epc_d    = pc;
    end else begin
      if (eret)           status_d = status_q >> STATUS_SHIFT;
      else if (wr_status) status_d = wdata;
      if (wr_cause)       cause_d  = wdata & ~CAUSE_IP7_MASK;
      if (wr_epc)         epc_d    = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q <= STATUS_RST;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  // IP7 is never stored; it is overlaid from the live timer flag on every read.
  always_comb begin
    case (rd)
      CP0_COUNT:   rdata = count_v;
      CP0_COMPARE: rdata = compare_v;
      CP0_STATUS:  rdata = status_q;
      CP0_CAUSE:   rdata = cause_q | (timer_int_v ? CAUSE_IP7_MASK : 32'h0);
      CP0_EPC:     rdata = epc_q;
      default:     rdata = 32'h0;
    endcase
  end

  assign status    = status_q;
  assign exc_addr  = (eret && !exception) ? epc_q : EXC_VECTOR;
  assign timer_int = timer_int_v;

endmodule
